// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: renders one sprite bitmap row per scanline.
// At each line start it decides whether the sprite covers the current line.
// If it does, the renderer fetches that bitmap row into a row buffer, one
// column per cycle. It then waits for the beam to reach sprite_x and shifts
// the row out on gfx.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   line_start            one-cycle pulse at the start of each line
//   hpos, vpos            current beam position
//   sprite_en             sprite visible (sampled on line_start)
//   sprite_x, sprite_y    sprite position
//   anim_state, direction sprite pose (latched on line_start)
//   rom_anim, rom_dir,    bitmap ROM address outputs
//   rom_yofs, rom_xofs
//   rom_bit               ROM pixel for the current address (same cycle)
//   gfx                   registered sprite pixel, 1 = opaque
//   busy                  renderer not idle
module sprite_line_renderer #(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned HEIGHT  = 12,
  parameter int unsigned COORD_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               sprite_en,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic               anim_state,
  input  logic [1:0]         direction,
  output logic               rom_anim,
  output logic [1:0]         rom_dir,
  output logic [3:0]         rom_yofs,
  output logic [3:0]         rom_xofs,
  input  logic               rom_bit,
  output logic               gfx,
  output logic               busy
);

  // The column counter must reach WIDTH to mark the end of the draw.
  localparam int unsigned COL_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_X,
    S_DRAW
  } state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               gfx_q, gfx_d;
  logic               busy_q, busy_d;
  logic               anim_q, anim_d;
  logic [1:0]         dir_q, dir_d;
  logic [3:0]         yofs_q, yofs_d;

  logic [COORD_W-1:0] row_c;
  logic               row_hit_c;
  logic               buf_pix_c;

  // Modulo subtraction makes a sprite near the bottom wrap onto the top lines.
  assign row_c     = vpos - sprite_y;
  assign row_hit_c = sprite_en && (row_c < COORD_W'(HEIGHT));

  // Row-buffer pixel selected by the column counter (0 beyond the last column).
  always_comb begin
    buf_pix_c = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (col_q == COL_W'(i)) begin
        buf_pix_c = buf_q[i];
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    buf_d   = buf_q;
    gfx_d   = 1'b0;
    anim_d  = anim_q;
    dir_d   = dir_q;
    yofs_d  = yofs_q;

    if (line_start) begin
      // A new line aborts whatever is in progress and re-evaluates the row.
      if (row_hit_c) begin
        state_d = S_FETCH;
        yofs_d  = 4'(row_c);
        anim_d  = anim_state;
        dir_d   = direction;
        col_d   = '0;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_FETCH: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (col_q == COL_W'(i)) begin
              buf_d[i] = rom_bit;
            end
          end
          col_d = col_q + COL_W'(1);
          if (col_q == COL_W'(WIDTH - 1)) begin
            state_d = S_WAIT_X;
          end
        end
        S_WAIT_X: begin
          if (hpos == sprite_x) begin
            gfx_d   = buf_q[0];
            col_d   = COL_W'(1);
            state_d = S_DRAW;
          end
        end
        S_DRAW: begin
          if (col_q < COL_W'(WIDTH)) begin
            gfx_d = buf_pix_c;
            col_d = col_q + COL_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      buf_q   <= '0;
      gfx_q   <= 1'b0;
      busy_q  <= 1'b0;
      anim_q  <= 1'b0;
      dir_q   <= 2'd0;
      yofs_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      gfx_q   <= gfx_d;
      busy_q  <= busy_d;
      anim_q  <= anim_d;
      dir_q   <= dir_d;
      yofs_q  <= yofs_d;
    end
  end

  assign rom_anim = anim_q;
  assign rom_dir  = dir_q;
  assign rom_yofs = yofs_q;
  assign rom_xofs = 4'(col_q);
  assign gfx      = gfx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: directed bench for sprite_line_renderer.
// A small behavioural bitmap ROM answers the renderer's addresses; expected
// pixel rows are written out by hand.
module tb_sprite_line_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_start;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       sprite_en;
  logic [8:0] sprite_x;
  logic [8:0] sprite_y;
  logic       anim_state;
  logic [1:0] direction;
  logic       rom_anim;
  logic [1:0] rom_dir;
  logic [3:0] rom_yofs;
  logic [3:0] rom_xofs;
  logic       rom_bit;
  logic       gfx;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  sprite_line_renderer #(.WIDTH(9), .HEIGHT(12), .COORD_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .hpos       (hpos),
    .vpos       (vpos),
    .sprite_en  (sprite_en),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .anim_state (anim_state),
    .direction  (direction),
    .rom_anim   (rom_anim),
    .rom_dir    (rom_dir),
    .rom_yofs   (rom_yofs),
    .rom_xofs   (rom_xofs),
    .rom_bit    (rom_bit),
    .gfx        (gfx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Bitmap ROM model; bit c of a row is column c (column 0 = leftmost).
  // Any non-zero pose inverts the row so that a wrongly latched pose shows up.
  function automatic logic [8:0] rom_model(input logic a, input logic [1:0] d,
                                           input logic [3:0] y);
    logic [8:0] r;
    case (y)
      4'd10:   r = 9'b111000011;
      4'd5:    r = 9'b101010101;
      default: r = 9'b011001100;
    endcase
    if (a || (d != 2'd0)) r = ~r;
    return r;
  endfunction

  logic [8:0] rom_row;
  always_comb begin
    rom_row = rom_model(rom_anim, rom_dir, rom_yofs);
    rom_bit = (rom_xofs < 4'd9) ? rom_row[rom_xofs] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge, then the beam advances.
  task automatic tick();
    @(posedge clk);
    #1;
    hpos = hpos + 9'd1;
  endtask

  task automatic wait_hpos(input logic [8:0] t);
    for (int i = 0; i < 600 && hpos != t; i++) tick();
    chk("wait_hpos", 32'(hpos), 32'(t));
  endtask

  task automatic start_line(input logic [8:0] vp, input logic [8:0] sy,
                            input logic [8:0] sx, input logic en);
    vpos       = vp;
    sprite_y   = sy;
    sprite_x   = sx;
    sprite_en  = en;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Full line: fetch check, wait for sprite_x, check all 9 pixels and the tail.
  task automatic run_line(input string tag, input logic [8:0] vp, input logic [8:0] sy,
                          input logic [8:0] sx, input logic [8:0] exp_row,
                          input logic [3:0] exp_yofs);
    hpos       = 9'd10;
    anim_state = 1'b0;
    direction  = 2'd0;
    start_line(vp, sy, sx, 1'b1);
    // Pose changes after line_start must not affect this line.
    anim_state = 1'b1;
    direction  = 2'd3;
    chk({tag, "_busy_fetch"}, 32'(busy), 32'd1);
    chk({tag, "_yofs"}, 32'(rom_yofs), 32'(exp_yofs));
    chk({tag, "_dir"}, 32'(rom_dir), 32'd0);
    for (int c = 0; c < 9; c++) begin
      chk({tag, "_xofs"}, 32'(rom_xofs), 32'(c));
      chk({tag, "_gfx_fetch"}, 32'(gfx), 32'd0);
      tick();
    end
    chk({tag, "_busy_waitx"}, 32'(busy), 32'd1);
    chk({tag, "_gfx_waitx"}, 32'(gfx), 32'd0);
    wait_hpos(sx);
    for (int c = 0; c < 9; c++) begin
      tick();
      chk({tag, "_gfx_px"}, 32'(gfx), 32'(exp_row[c]));
    end
    tick();
    chk({tag, "_gfx_tail"}, 32'(gfx), 32'd0);
    chk({tag, "_busy_tail"}, 32'(busy), 32'd0);
    anim_state = 1'b0;
    direction  = 2'd0;
  endtask

  // Line that must not draw: stays idle and gfx never rises.
  task automatic idle_line(input string tag, input logic [8:0] vp, input logic [8:0] sy,
                           input logic en);
    logic seen;
    seen = 1'b0;
    hpos = 9'd10;
    start_line(vp, sy, 9'd40, en);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_yofs_kept"}, 32'(rom_yofs), 32'd10);
    for (int i = 0; i < 60; i++) begin
      if (gfx) seen = 1'b1;
      tick();
    end
    chk({tag, "_gfx_never"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic seen;
    reset      = 1'b1;
    line_start = 1'b0;
    hpos       = 9'd0;
    vpos       = 9'd0;
    sprite_en  = 1'b0;
    sprite_x   = 9'd0;
    sprite_y   = 9'd0;
    anim_state = 1'b0;
    direction  = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_gfx", 32'(gfx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_yofs", 32'(rom_yofs), 32'd0);
    chk("rst_xofs", 32'(rom_xofs), 32'd0);
    chk("rst_dir", 32'(rom_dir), 32'd0);
    chk("rst_anim", 32'(rom_anim), 32'd0);

    // Basic row 10: gfx 1,1,0,0,0,0,1,1,1.
    run_line("row10", 9'd100, 9'd90, 9'd40, 9'b111000011, 4'd10);

    // Row just past the bottom, and line just above the top.
    idle_line("row12", 9'd112, 9'd100, 1'b1);
    idle_line("above", 9'd99, 9'd100, 1'b1);
    // Sprite disabled while the line is inside it.
    idle_line("disabled", 9'd100, 9'd90, 1'b0);

    // Vertical wrap: sprite_y=510, vpos=3 selects row 5.
    run_line("wrap", 9'd3, 9'd510, 9'd40, 9'b101010101, 4'd5);

    // Abort in the 4th DRAW cycle with a line outside the sprite.
    hpos = 9'd10;
    start_line(9'd100, 9'd90, 9'd40, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    wait_hpos(9'd40);
    tick(); chk("abort_px0", 32'(gfx), 32'd1);
    tick(); chk("abort_px1", 32'(gfx), 32'd1);
    tick(); chk("abort_px2", 32'(gfx), 32'd0);
    start_line(9'd200, 9'd90, 9'd40, 1'b1);
    chk("abort_out_gfx", 32'(gfx), 32'd0);
    chk("abort_out_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (gfx) seen = 1'b1;
      tick();
    end
    chk("abort_out_quiet", 32'(seen), 32'd0);

    // Abort in DRAW with a line inside the sprite: fresh fetch from column 0.
    hpos = 9'd10;
    start_line(9'd100, 9'd90, 9'd40, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    wait_hpos(9'd40);
    tick();
    tick();
    tick();
    start_line(9'd101, 9'd90, 9'd40, 1'b1);
    chk("refetch_busy", 32'(busy), 32'd1);
    chk("refetch_gfx", 32'(gfx), 32'd0);
    chk("refetch_xofs0", 32'(rom_xofs), 32'd0);
    chk("refetch_yofs", 32'(rom_yofs), 32'd11);
    tick();
    chk("refetch_xofs1", 32'(rom_xofs), 32'd1);

    // Reset mid-FETCH with direction 3 latched.
    hpos      = 9'd10;
    direction = 2'd3;
    start_line(9'd100, 9'd90, 9'd40, 1'b1);
    tick();
    tick();
    chk("rstmid_dir_latched", 32'(rom_dir), 32'd3);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_gfx", 32'(gfx), 32'd0);
    chk("rstmid_dir", 32'(rom_dir), 32'd0);
    chk("rstmid_xofs", 32'(rom_xofs), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (gfx || busy) seen = 1'b1;
      tick();
    end
    chk("rstmid_no_draw", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
